// File: rtl/lb_cnt_pkg.sv
// Shared FSM encoding and terminal-action mode names for the loadable counter.
package lb_cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam string MODE_CONTINUOUS = "CONTINUOUS";
    localparam string MODE_ONESHOT    = "ONESHOT";

endpackage

// File: rtl/lb_cnt_slice.sv
// 2-bit up/down counter slice with ripple carry; loads {D1,D0} when LOAD.
// Latency: Q updates one CK after CE; CO is combinational from Q, CI, CON.
// Backpressure: CE=0 freezes the slice; no handshake.
module lb_cnt_slice (
    input  logic CK,
    input  logic RSTN,
    input  logic D0,
    input  logic D1,
    input  logic CI,
    input  logic CON,
    input  logic LOAD,
    input  logic CE,
    output logic Q0,
    output logic Q1,
    output logic CO
);

    logic [1:0] q;
    logic       cnt;

    // Carry is active-high going up, active-low (borrow) going down.
    assign cnt = CON ? CI : ~CI;
    assign CO  = CON ? (CI & q[0] & q[1]) : (CI | q[0] | q[1]);

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            q <= 2'b00;
        end else if (CE) begin
            if (LOAD) begin
                q <= {D1, D0};
            end else if (cnt) begin
                q <= CON ? (q + 2'd1) : (q - 2'd1);
            end
        end
    end

    assign Q0 = q[0];
    assign Q1 = q[1];

endmodule

// File: rtl/lb_cnt_ctrl.sv
// Loadable up/down counter with reload-on-terminal, TC pulse and one-shot mode.
// Latency: Q/TC/BUSY registered (1 CK); CO combinational from Q and CI.
// Backpressure: SP=0 freezes all state; no handshake.
module lb_cnt_ctrl
    import lb_cnt_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter string MODE  = MODE_CONTINUOUS
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             SP,
    input  logic             CI,
    input  logic             CON,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TC,
    output logic             BUSY
);

    localparam int NS      = WIDTH / 2;
    localparam bit ONESHOT = (MODE == MODE_ONESHOT);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("lb_cnt_ctrl: WIDTH must be even and at least 2");
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] rld_q;
    logic             tc_q;
    logic [NS:0]      carry;
    logic [WIDTH-1:0] slice_d;
    logic             run;
    logic             term;
    logic             slice_load;
    logic             slice_ce;

    assign run   = (state_q == ST_RUN);
    // The chain's final carry/borrow already folds in the all-ones/all-zeros test.
    assign term  = SP & run & (CON ? CO : ~CO);

    assign slice_load = LOAD | term;
    assign slice_d    = LOAD ? D : rld_q;
    assign slice_ce   = SP & (LOAD | run);

    assign carry[0] = CI;
    assign CO       = carry[NS];

    for (genvar k = 0; k < NS; k++) begin : g_slice
        lb_cnt_slice u_slice (
            .CK   (CK),
            .RSTN (RSTN),
            .D0   (slice_d[2*k]),
            .D1   (slice_d[2*k+1]),
            .CI   (carry[k]),
            .CON  (CON),
            .LOAD (slice_load),
            .CE   (slice_ce),
            .Q0   (Q[2*k]),
            .Q1   (Q[2*k+1]),
            .CO   (carry[k+1])
        );
    end

    always_comb begin
        state_d = state_q;
        if (SP) begin
            if (LOAD) begin
                state_d = ST_RUN;
            end else if (term && ONESHOT) begin
                state_d = ST_STOP;
            end
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            rld_q   <= '0;
            tc_q    <= 1'b0;
        end else if (SP) begin
            state_q <= state_d;
            tc_q    <= term & ~LOAD;
            if (LOAD) begin
                rld_q <= D;
            end
        end
    end

    assign TC   = tc_q;
    assign BUSY = run;

endmodule

// File: tb/tb_lb_cnt_ctrl.sv
// Scoreboard bench: continuous and one-shot counters share stimulus, checked against a reference model.
module tb_lb_cnt_ctrl;

    logic       CK = 1'b0;
    logic       rstn, sp, ci, con, load;
    logic [7:0] d;
    logic [7:0] q_c, q_o;
    logic       co_c, co_o, tc_c, tc_o, busy_c, busy_o;

    always #5 CK = ~CK;

    lb_cnt_ctrl #(.WIDTH(8), .MODE("CONTINUOUS")) u_cont (
        .CK(CK), .RSTN(rstn), .SP(sp), .CI(ci), .CON(con), .LOAD(load), .D(d),
        .Q(q_c), .CO(co_c), .TC(tc_c), .BUSY(busy_c)
    );

    lb_cnt_ctrl #(.WIDTH(8), .MODE("ONESHOT")) u_once (
        .CK(CK), .RSTN(rstn), .SP(sp), .CI(ci), .CON(con), .LOAD(load), .D(d),
        .Q(q_o), .CO(co_o), .TC(tc_o), .BUSY(busy_o)
    );

    typedef struct {
        logic [7:0] q;
        logic       co;
        logic       tc;
        logic       busy;
    } exp_t;

    exp_t expq[$];

    localparam int IDLE = 0, RUN = 1, STOP = 2;
    int mq[2], mrld[2], mst[2], mtc[2];
    int checks = 0, passes = 0;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mrld[i] = 0; mst[i] = IDLE; mtc[i] = 0;
        end
    endfunction

    // Model index 0 is the continuous counter, 1 the one-shot counter.
    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            if (sp) begin
                int ntc = 0;
                if (load) begin
                    mq[i] = d; mrld[i] = d; mst[i] = RUN;
                end else if (mst[i] == RUN && (con ? ci : !ci)) begin
                    if ((con && mq[i] == 255) || (!con && mq[i] == 0)) begin
                        mq[i] = mrld[i];
                        ntc = 1;
                        if (i == 1) mst[i] = STOP;
                    end else begin
                        mq[i] = con ? (mq[i] + 1) % 256 : (mq[i] + 255) % 256;
                    end
                end
                mtc[i] = ntc;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input logic r, input logic s, input logic c, input logic n,
                       input logic l, input logic [7:0] dv);
        exp_t e;
        @(posedge CK);
        #1;
        if (rstn) model_edge();
        rstn = r; sp = s; ci = c; con = n; load = l; d = dv;
        if (!r) model_reset();
        for (int i = 0; i < 2; i++) begin
            e.q    = 8'(mq[i]);
            e.tc   = (mtc[i] != 0);
            e.busy = (mst[i] == RUN);
            e.co   = con ? (mq[i] == 255 && ci) : !(mq[i] == 0 && !ci);
            expq.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t ec, eo;
        forever begin
            @(negedge CK);
            if (expq.size() >= 2) begin
                ec = expq.pop_front();
                eo = expq.pop_front();
                chk("cont_q",    q_c,         ec.q);
                chk("cont_co",   {7'd0, co_c},   {7'd0, ec.co});
                chk("cont_tc",   {7'd0, tc_c},   {7'd0, ec.tc});
                chk("cont_busy", {7'd0, busy_c}, {7'd0, ec.busy});
                chk("once_q",    q_o,         eo.q);
                chk("once_co",   {7'd0, co_o},   {7'd0, eo.co});
                chk("once_tc",   {7'd0, tc_o},   {7'd0, eo.tc});
                chk("once_busy", {7'd0, busy_o}, {7'd0, eo.busy});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stimulus
        rstn = 1'b0; sp = 1'b0; ci = 1'b0; con = 1'b1; load = 1'b0; d = 8'h00;
        model_reset();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        // Async reset between edges while counting at 37
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h37);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        // Up from FD through the terminal reload
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFD);
        repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        // Down from 02, then hold
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02);
        repeat (14) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // Enable freeze at FF, then release into the wrap
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFE);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        // LOAD colliding with terminal at FF
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFE);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        // TC held through SP=0 after the terminal edge
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        // Inactive carry in RUN at 5A
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 800; k++) begin
            logic [7:0] dv;
            case ($urandom_range(0, 7))
                0: dv = 8'hFF;
                1: dv = 8'h00;
                2: dv = 8'hFE;
                3: dv = 8'h01;
                default: dv = 8'($urandom);
            endcase
            cyc(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 99) < 85),
                1'($urandom), 1'($urandom), 1'($urandom_range(0, 99) < 10), dv);
        end
        repeat (3) @(negedge CK);
        #1;
        checks++;
        if (expq.size() == 0) passes++;
        else $display("FAIL queue_drain actual=%0d required=0", expq.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lb_cnt_ctrl.md
LB_CNT_CTRL -- requirements
Module: lb_cnt_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width; it must be even and at least 2.
REQ-002 The block SHALL have parameter MODE, default "CONTINUOUS", selecting the terminal action; the only other value is "ONESHOT".
REQ-003 Port CK SHALL be input, 1 bit, the clock; all state changes on its rising edge.
REQ-004 Port RSTN SHALL be input, 1 bit, the reset: asynchronous, active-low.
REQ-005 Port SP SHALL be input, 1 bit, the clock enable; when 0 it freezes all state.
REQ-006 Port CI SHALL be input, 1 bit, the count/carry-in: active-high in up mode, active-low (borrow-in) in down mode.
REQ-007 Port CON SHALL be input, 1 bit, the direction: 1 = up, 0 = down.
REQ-008 Port LOAD SHALL be input, 1 bit, the synchronous load/start strobe.
REQ-009 Port D SHALL be input, WIDTH bits, the load and reload value.
REQ-010 Port Q SHALL be output, WIDTH bits, the registered count.
REQ-011 Port CO SHALL be output, 1 bit, the combinational carry-out: active-high carry in up mode, active-low borrow in down mode.
REQ-012 Port TC SHALL be output, 1 bit, a registered one-cycle terminal-count pulse.
REQ-013 Port BUSY SHALL be output, 1 bit, registered; it is 1 in state RUN.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and STOP.
REQ-015 A count event SHALL be defined as SP=1 and state RUN and (CON=1 and CI=1, or CON=0 and CI=0).
REQ-016 On a count event, Q SHALL become Q+1 mod 2^WIDTH when up and Q-1 when down.
REQ-017 CO SHALL be 1 in up mode when Q is all ones and CI=1, else 0.
REQ-018 CO SHALL be 0 in down mode when Q is all zeros and CI=0, else 1; CO is independent of state and SP.
REQ-019 A terminal event SHALL be a count event with Q all ones when up, or Q all zeros when down.
REQ-020 On a terminal event, Q SHALL take the reload register RLD instead of wrapping, and TC SHALL be 1 in the following cycle only.
REQ-021 On a terminal event, the state SHALL remain RUN when MODE is "CONTINUOUS" and go to STOP when MODE is "ONESHOT".
REQ-022 With SP=1 and LOAD=1, Q and RLD SHALL both take D and the state SHALL go to RUN from any state; no count happens that cycle.
REQ-023 LOAD SHALL take priority over a simultaneous count or terminal event; TC then stays 0.
REQ-024 In IDLE and STOP, Q SHALL hold and TC SHALL be 0; CO still reflects Q and CI.
REQ-025 With SP=0, Q, RLD, the state and TC SHALL hold their values; a TC already at 1 is cleared at the next SP=1 edge.
REQ-026 A change of CON mid-run SHALL take effect on the next count event with no pipeline latency.

Reset
REQ-027 While RSTN=0, the block SHALL set Q=0, RLD=0, TC=0, BUSY=0 and state IDLE asynchronously, without waiting for CK.
REQ-028 An RSTN assertion mid-count or mid-TC-pulse SHALL abort immediately; after release the block waits in IDLE for LOAD.

Structure
REQ-029 The state encoding and the MODE string constants SHALL live in a shared package, lb_cnt_pkg.
REQ-030 The count path SHALL be WIDTH/2 instances of one sub-module, lb_cnt_slice: a 2-bit up/down slice with carry chain.
REQ-031 Each lb_cnt_slice SHALL have inputs D0, D1, CI, CON, LOAD, CE and outputs Q0, Q1, CO; slice k's CO feeds slice k+1's CI, and the last slice's CO is the block's CO.
REQ-032 The FSM, RLD register and TC register SHALL be in lb_cnt_ctrl itself, not in the slices.

Verification (WIDTH=8)
REQ-033 Reset: assert RSTN=0 between edges while Q=8'h37 in RUN -> Q=8'h00, TC=0 and BUSY=0 before the next CK edge.
REQ-034 Continuous up: load D=8'hFD, then CON=1, CI=1, SP=1 -> Q goes FE, FF, FD; CO=1 only while Q=FF; TC=1 exactly in the cycle after FF->FD; BUSY stays 1.
REQ-035 One-shot down: MODE "ONESHOT", load D=8'h02, CON=0, CI=0 -> Q goes 01, 00, 02; CO=0 while Q=00; TC pulses once; BUSY=0; Q stays 02 for 10 more cycles.
REQ-036 Enable hold: at Q=FF up with CI=1, drive SP=0 for 5 cycles -> Q=FF and TC=0 throughout; on SP=1, Q wraps to RLD and TC pulses.
REQ-037 LOAD versus terminal: at Q=FF up with CI=1, assert LOAD with D=8'h10 -> Q=10, RLD=10, TC=0.
REQ-038 Inactive carry: CON=1, CI=0 in RUN at Q=8'h5A for 4 cycles -> Q holds 5A and CO=0.
